// File: rtl/rtc_time_latch_pkg.sv
// Shared constants and types for the RTC time latch: digit encoding,
// burst byte slots, FSM states and the shadow time record.
package rtc_time_latch_pkg;

    localparam logic [4:0] DIGIT_BLANK = 5'h10;

    localparam int unsigned BYTE_SEC  = 0;
    localparam int unsigned BYTE_MIN  = 1;
    localparam int unsigned BYTE_HOUR = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] hr_t;
        logic [3:0] hr_u;
        logic [3:0] mn_t;
        logic [3:0] mn_u;
        logic [3:0] sc_t;
        logic [3:0] sc_u;
        logic       pm;
    } time_t;

    function automatic logic [4:0] to_digit(input logic [3:0] d);
        return {1'b0, d};
    endfunction

endpackage

// File: rtl/rtc_time_latch_field.sv
// Combinational BCD field splitter and range check: tens/units of a 7-bit
// field, valid when tens, units and the decimal value are all in range.
module rtc_bcd_field (
    input  logic [6:0] field_in,
    input  logic [3:0] max_tens,
    input  logic [6:0] max_value,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       valid
);
    logic [6:0] value_s;

    // Split the field and check every BCD limit at once
    always_comb begin
        tens    = {1'b0, field_in[6:4]};
        units   = field_in[3:0];
        value_s = {3'b000, tens} * 7'd10 + {3'b000, units};
        valid   = (tens <= max_tens) && (units <= 4'd9) && (value_s <= max_value);
    end

endmodule

// File: rtl/rtc_time_latch.sv
// Validates RTC burst frames into a shadow record, commits it atomically to the
// display snapshot and serves one digit per request, blanking when stale.
module rtc_time_latch #(
    parameter int unsigned BURST_LEN   = 8,
    parameter int unsigned STALE_LIMIT = 16,
    parameter int unsigned BLANK_LEAD  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       frame_start,
    input  logic       tick,
    input  logic [2:0] rd_pos,
    output logic [4:0] digit_out,
    output logic       pm,
    output logic       stale,
    output logic       frame_ok,
    output logic       frame_err
);
    import rtc_time_latch_pkg::*;

    localparam int unsigned      IDX_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [7:0]       STALE_MAX = 8'(STALE_LIMIT);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    time_t            shadow_q, shadow_d;
    logic [5:0][4:0]  snap_q, snap_d;
    logic             pm_q, pm_d;
    logic [7:0]       stale_cnt_q, stale_cnt_d;
    logic             committed_q, committed_d;
    logic             stale_q, stale_d;
    logic [4:0]       digit_q, digit_d;
    logic             frame_ok_q, frame_ok_d;
    logic             frame_err_q, frame_err_d;

    logic             accept_s, restart_s, field_bad_s;
    logic [IDX_W-1:0] byte_idx_s;
    logic [3:0]       sc_t_s, sc_u_s, mn_t_s, mn_u_s, hr_t_s, hr_u_s;
    logic             sc_ok_s, mn_ok_s, hr_ok_s, hr_12h_s;
    logic [6:0]       hr_field_s, hr_max_val_s;
    logic [3:0]       hr_max_tens_s;

    rtc_bcd_field u_sec (.field_in(byte_in[6:0]), .max_tens(4'd5), .max_value(7'd59),
                         .tens(sc_t_s), .units(sc_u_s), .valid(sc_ok_s));
    rtc_bcd_field u_min (.field_in(byte_in[6:0]), .max_tens(4'd5), .max_value(7'd59),
                         .tens(mn_t_s), .units(mn_u_s), .valid(mn_ok_s));
    rtc_bcd_field u_hour (.field_in(hr_field_s), .max_tens(hr_max_tens_s), .max_value(hr_max_val_s),
                          .tens(hr_t_s), .units(hr_u_s), .valid(hr_ok_s));

    // Hours byte: bit7 selects 12 h (tens = bit4, bit5 = PM) or 24 h (tens = bits 5:4)
    always_comb begin
        hr_12h_s = byte_in[7];
        if (hr_12h_s) begin
            hr_field_s    = {3'b000, byte_in[4], byte_in[3:0]};
            hr_max_tens_s = 4'd1;
            hr_max_val_s  = 7'd12;
        end else begin
            hr_field_s    = {2'b00, byte_in[5:4], byte_in[3:0]};
            hr_max_tens_s = 4'd2;
            hr_max_val_s  = 7'd23;
        end
    end

    // Classify the incoming byte: part of a frame, and which slot it fills
    always_comb begin
        accept_s   = 1'b0;
        restart_s  = 1'b0;
        byte_idx_s = '0;
        case (state_q)
            ST_RECV: begin
                if (byte_valid) begin
                    accept_s   = 1'b1;
                    restart_s  = frame_start;
                    byte_idx_s = frame_start ? '0 : (idx_q + IDX_ONE);
                end else begin
                    accept_s = 1'b0;
                end
            end
            default: begin
                accept_s = byte_valid & frame_start;
            end
        endcase
    end

    // Frame FSM, shadow capture and atomic snapshot commit
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        err_d       = err_q;
        shadow_d    = shadow_q;
        snap_d      = snap_q;
        pm_d        = pm_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        field_bad_s = 1'b0;
        if (state_q == ST_COMMIT) begin
            snap_d[0]  = to_digit(shadow_q.hr_t);
            snap_d[1]  = to_digit(shadow_q.hr_u);
            snap_d[2]  = to_digit(shadow_q.mn_t);
            snap_d[3]  = to_digit(shadow_q.mn_u);
            snap_d[4]  = to_digit(shadow_q.sc_t);
            snap_d[5]  = to_digit(shadow_q.sc_u);
            pm_d       = shadow_q.pm;
            frame_ok_d = 1'b1;
            state_d    = ST_IDLE;
        end else begin
            snap_d = snap_q;
        end
        if (accept_s) begin
            idx_d       = byte_idx_s;
            frame_err_d = restart_s;
            case (byte_idx_s)
                IDX_W'(BYTE_SEC): begin
                    shadow_d.sc_t = sc_t_s;
                    shadow_d.sc_u = sc_u_s;
                    field_bad_s   = ~sc_ok_s;
                end
                IDX_W'(BYTE_MIN): begin
                    shadow_d.mn_t = mn_t_s;
                    shadow_d.mn_u = mn_u_s;
                    field_bad_s   = ~mn_ok_s;
                end
                IDX_W'(BYTE_HOUR): begin
                    shadow_d.hr_t = hr_t_s;
                    shadow_d.hr_u = hr_u_s;
                    shadow_d.pm   = hr_12h_s & byte_in[5];
                    field_bad_s   = ~hr_ok_s | (hr_12h_s & (hr_t_s == 4'd0) & (hr_u_s == 4'd0));
                end
                default: begin
                    field_bad_s = 1'b0;
                end
            endcase
            err_d = ((byte_idx_s == '0) ? 1'b0 : err_q) | field_bad_s;
            if (byte_idx_s == LAST_IDX) begin
                state_d     = err_d ? ST_IDLE : ST_COMMIT;
                frame_err_d = err_d;
            end else begin
                state_d = ST_RECV;
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Stale timer: a commit clears it even when a tick lands in the same cycle
    always_comb begin
        committed_d = committed_q;
        if (state_q == ST_COMMIT) begin
            stale_cnt_d = 8'd0;
            committed_d = 1'b1;
        end else if (tick && (stale_cnt_q != STALE_MAX)) begin
            stale_cnt_d = stale_cnt_q + 8'd1;
        end else begin
            stale_cnt_d = stale_cnt_q;
        end
        stale_d = (stale_cnt_d == STALE_MAX) | ~committed_d;
    end

    // Display read mux
    always_comb begin
        digit_d = DIGIT_BLANK;
        if (stale_q) begin
            digit_d = DIGIT_BLANK;
        end else begin
            case (rd_pos)
                3'd0:    digit_d = ((BLANK_LEAD != 0) && (snap_q[0] == 5'd0)) ? DIGIT_BLANK : snap_q[0];
                3'd1:    digit_d = snap_q[1];
                3'd2:    digit_d = snap_q[2];
                3'd3:    digit_d = snap_q[3];
                3'd4:    digit_d = snap_q[4];
                3'd5:    digit_d = snap_q[5];
                default: digit_d = DIGIT_BLANK;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            err_q       <= 1'b0;
            shadow_q    <= '0;
            snap_q      <= {6{DIGIT_BLANK}};
            pm_q        <= 1'b0;
            stale_cnt_q <= 8'd0;
            committed_q <= 1'b0;
            stale_q     <= 1'b1;
            digit_q     <= DIGIT_BLANK;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            shadow_q    <= shadow_d;
            snap_q      <= snap_d;
            pm_q        <= pm_d;
            stale_cnt_q <= stale_cnt_d;
            committed_q <= committed_d;
            stale_q     <= stale_d;
            digit_q     <= digit_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign digit_out = digit_q;
    assign pm        = pm_q;
    assign stale     = stale_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rtc_time_latch.sv
// Scoreboard bench for rtc_time_latch: directed and random bursts, ticks and
// reads against a decimal-arithmetic reference model of the time snapshot.
module tb_rtc_time_latch;

    localparam int BLANK = 16;
    localparam int LIMIT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] byte_in;
    logic       byte_valid, frame_start, tick;
    logic [2:0] rd_pos;
    logic       rd_chk;
    logic [4:0] digit_out;
    logic       pm, stale, frame_ok, frame_err;

    typedef struct {
        int pos;
        int dig;
        bit st;
        bit p;
    } rd_t;

    rd_t rd_q[$];
    int  ev_q[$];
    int  total = 0;
    int  bad = 0;

    int  m_dig[6];
    bit  m_pm;
    bit  m_committed;
    int  m_ticks;
    int  f_dig[6];
    bit  f_pm;
    logic mon_chk;

    rtc_time_latch dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .frame_start(frame_start), .tick(tick), .rd_pos(rd_pos),
        .digit_out(digit_out), .pm(pm), .stale(stale),
        .frame_ok(frame_ok), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Monitor: frame events and read responses checked just after each edge
    always @(posedge clk) begin
        mon_chk = rd_chk;
        #1;
        if (frame_ok || frame_err) begin
            int got;
            int want;
            got = frame_ok ? (frame_err ? 3 : 1) : 2;
            total++;
            if (ev_q.size() == 0) begin
                bad++;
                $display("FAIL event: got=%0d (1=ok 2=err 3=both) with none expected", got);
            end else begin
                want = ev_q.pop_front();
                if (got != want) begin
                    bad++;
                    $display("FAIL event: got=%0d want=%0d", got, want);
                end
            end
        end
        if (mon_chk) begin
            rd_t r;
            if (rd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL read: no expectation queued");
            end else begin
                r = rd_q.pop_front();
                total += 3;
                if (int'(digit_out) != r.dig) begin
                    bad++;
                    $display("FAIL digit pos=%0d: got=%0d want=%0d", r.pos, digit_out, r.dig);
                end
                if (stale != r.st) begin
                    bad++;
                    $display("FAIL stale pos=%0d: got=%0d want=%0d", r.pos, stale, r.st);
                end
                if (pm != r.p) begin
                    bad++;
                    $display("FAIL pm pos=%0d: got=%0d want=%0d", r.pos, pm, r.p);
                end
            end
        end
    end

    // Reference decode: seconds/minutes 00..59, hours 0..23 or 1..12 with PM
    task automatic model_frame(input logic [7:0] b0, b1, b2, output bit ok);
        int hv;
        f_dig[4] = int'(b0[6:4]);
        f_dig[5] = int'(b0[3:0]);
        f_dig[2] = int'(b1[6:4]);
        f_dig[3] = int'(b1[3:0]);
        ok = (f_dig[4] <= 5) && (f_dig[5] <= 9) && (f_dig[2] <= 5) && (f_dig[3] <= 9);
        f_dig[1] = int'(b2[3:0]);
        if (b2[7]) begin
            f_dig[0] = int'(b2[4]);
            f_pm     = b2[5];
            hv       = f_dig[0] * 10 + f_dig[1];
            ok       = ok && (f_dig[1] <= 9) && (hv >= 1) && (hv <= 12);
        end else begin
            f_dig[0] = int'(b2[5:4]);
            f_pm     = 1'b0;
            hv       = f_dig[0] * 10 + f_dig[1];
            ok       = ok && (f_dig[1] <= 9) && (hv <= 23);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_dig[i] = BLANK;
        m_pm        = 1'b0;
        m_committed = 1'b0;
        m_ticks     = 0;
    endtask

    task automatic model_tick();
        if (m_ticks < LIMIT) m_ticks++;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fs);
        byte_in     = b;
        byte_valid  = 1'b1;
        frame_start = fs;
        @(negedge clk);
        byte_valid  = 1'b0;
        frame_start = 1'b0;
        byte_in     = 8'($urandom);
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, input bit tick_commit);
        bit ok;
        model_frame(b0, b1, b2, ok);
        ev_q.push_back(ok ? 1 : 2);
        for (int i = 0; i < 8; i++) begin
            case (i)
                0:       send_byte(b0, 1'b1);
                1:       send_byte(b1, 1'b0);
                2:       send_byte(b2, 1'b0);
                default: send_byte(8'($urandom), 1'b0);
            endcase
            if (i < 7) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        tick = tick_commit;
        @(negedge clk);
        tick = 1'b0;
        if (ok) begin
            for (int i = 0; i < 6; i++) m_dig[i] = f_dig[i];
            m_pm        = f_pm;
            m_committed = 1'b1;
            m_ticks     = 0;
        end else if (tick_commit) begin
            model_tick();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic send_restart(input int k, input logic [7:0] b0, b1, b2);
        ev_q.push_back(2);
        for (int i = 0; i < k; i++) send_byte(8'($urandom), (i == 0) ? 1'b1 : 1'b0);
        send_frame(b0, b1, b2, 1'b0);
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            model_tick();
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic read_pos(input int pos);
        rd_t r;
        bit  st;
        st    = !m_committed || (m_ticks >= LIMIT);
        r.pos = pos;
        r.st  = st;
        r.p   = m_pm;
        if (st || pos > 5) r.dig = BLANK;
        else if (pos == 0 && m_dig[0] == 0) r.dig = BLANK;
        else r.dig = m_dig[pos];
        rd_q.push_back(r);
        rd_pos = 3'(pos);
        rd_chk = 1'b1;
        @(negedge clk);
        rd_chk = 1'b0;
    endtask

    task automatic read_all();
        for (int p = 0; p < 8; p++) read_pos(p);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    function automatic logic [7:0] rnd_ms();
        if ($urandom_range(0, 4) == 0) return 8'($urandom);
        return {1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
    endfunction

    function automatic logic [7:0] rnd_hr();
        int r;
        r = $urandom_range(0, 5);
        if (r == 0) return 8'($urandom);
        if (r <= 2) return {1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
        return {1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
    endfunction

    initial begin
        rst = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; frame_start = 1'b0;
        tick = 1'b0; rd_pos = 3'd0; rd_chk = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        read_all();

        send_frame(8'h85, 8'h42, 8'h13, 1'b0);
        read_all();
        send_frame(8'h85, 8'h42, 8'hB2, 1'b0);
        read_all();
        send_frame(8'h85, 8'h42, 8'h24, 1'b0);
        read_all();
        send_restart(4, 8'h30, 8'h59, 8'h23);
        read_all();

        do_ticks(15);
        read_all();
        do_ticks(1);
        read_all();

        send_frame(8'h11, 8'h22, 8'h07, 1'b0);
        read_all();
        do_ticks(15);
        send_frame(8'h48, 8'h37, 8'h91, 1'b1);
        read_all();
        do_ticks(15);
        read_pos(1);
        do_ticks(1);
        read_pos(1);

        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        send_byte(8'h15, 1'b0);
        do_reset();
        read_all();
        send_frame(8'h59, 8'h59, 8'h23, 1'b0);
        read_all();

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0:       send_restart($urandom_range(1, 6), rnd_ms(), rnd_ms(), rnd_hr());
                1:       do_ticks($urandom_range(0, 20));
                default: send_frame(rnd_ms(), rnd_ms(), rnd_hr(), 1'($urandom_range(0, 1)));
            endcase
            read_pos($urandom_range(0, 7));
            read_pos($urandom_range(0, 7));
        end

        repeat (4) @(negedge clk);
        total++;
        if (ev_q.size() != 0 || rd_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: events=%0d reads=%0d want 0", ev_q.size(), rd_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
